// File: rtl/match_referee_pkg.sv
// Shared definitions for the fighter state words and the match referee.
// Player FSMs and the referee both import this package.
package match_referee_pkg;

   localparam int PLACE_HI  = 3;
   localparam int PLACE_LO  = 2;
   localparam int HEALTH_HI = 1;
   localparam int HEALTH_LO = 0;

   localparam logic [1:0] HEALTH_FULL = 2'd3;

   typedef enum logic [1:0] {
      W_NONE = 2'b00,
      W_P1   = 2'b01,
      W_P2   = 2'b10,
      W_DRAW = 2'b11
   } winner_e;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FIGHT      = 3'd1,
      S_ROUND_END  = 3'd2,
      S_NEXT_ROUND = 3'd3,
      S_GAME_OVER  = 3'd4
   } ref_state_e;

   function automatic logic [1:0] health_of(input logic [3:0] word);
      return word[HEALTH_HI:HEALTH_LO];
   endfunction

   function automatic logic [1:0] place_of(input logic [3:0] word);
      return word[PLACE_HI:PLACE_LO];
   endfunction

   // Round and win counters stick at their maximum instead of wrapping.
   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/match_referee_if.sv
// Signal bundle between the game side (players, start/tick source, display)
// and the match referee.
interface match_referee_if;

   logic       start;
   logic       tick;
   logic [3:0] p1_state;
   logic [3:0] p2_state;
   logic       player_rst_n;
   logic       fighting;
   logic [5:0] time_left;
   logic [2:0] round_num;
   logic [2:0] p1_wins;
   logic [2:0] p2_wins;
   logic [1:0] round_winner;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output start, tick, p1_state, p2_state,
      input  player_rst_n, fighting, time_left, round_num,
             p1_wins, p2_wins, round_winner, game_over, winner
   );

   modport slave (
      input  start, tick, p1_state, p2_state,
      output player_rst_n, fighting, time_left, round_num,
             p1_wins, p2_wins, round_winner, game_over, winner
   );

endinterface

// File: rtl/match_referee_round_timer.sv
// Loadable tick-driven down counter that stops at zero.
// Used as both the round clock and the post-round hold counter.
module round_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && tick && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/match_referee.sv
// Round/match controller: decides rounds by KO or timeout, keeps score and
// drives the shared reset of the two player FSMs.
//
// state        | meaning
// S_IDLE       | after reset, players held in reset, waiting for start
// S_NEXT_ROUND | one-cycle player reset pulse before a round
// S_FIGHT      | round running, round clock counting down
// S_ROUND_END  | result shown, hold counter running, players frozen
// S_GAME_OVER  | match decided, players held in reset, waiting for start
module match_referee
   import match_referee_pkg::*;
#(
   parameter int ROUND_TIME = 45,
   parameter int WIN_ROUNDS = 2,
   parameter int MAX_ROUNDS = 5,
   parameter int HOLD_TICKS = 3
) (
   input  logic           clk,
   input  logic           reset,
   match_referee_if.slave bus
);

   ref_state_e state_q, state_d;
   logic [2:0] p1_wins_q, p1_wins_d;
   logic [2:0] p2_wins_q, p2_wins_d;
   logic [2:0] round_num_q, round_num_d;
   winner_e    round_winner_q, round_winner_d;
   winner_e    winner_q, winner_d;

   logic       time_load, time_en, time_zero;
   logic [5:0] time_cnt;
   logic       hold_load, hold_en, hold_zero;
   logic [5:0] hold_cnt_unused;
   logic [3:0] places_unused;

   logic [1:0] h1, h2;
   logic       round_over, match_done;
   winner_e    outcome, match_lead;

   round_timer #(.W(6)) u_round_clock (
      .clk      (clk),
      .reset    (reset),
      .load     (time_load),
      .load_val (6'(ROUND_TIME)),
      .tick     (bus.tick),
      .en       (time_en),
      .count    (time_cnt),
      .zero     (time_zero)
   );

   round_timer #(.W(6)) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .load_val (6'(HOLD_TICKS)),
      .tick     (bus.tick),
      .en       (hold_en),
      .count    (hold_cnt_unused),
      .zero     (hold_zero)
   );

   // Place has no say in who wins a round.
   assign places_unused = {place_of(bus.p1_state), place_of(bus.p2_state)};
   assign h1 = health_of(bus.p1_state);
   assign h2 = health_of(bus.p2_state);

   assign round_over = (h1 == 2'd0) || (h2 == 2'd0) || time_zero;
   assign match_done = (p1_wins_q == 3'(WIN_ROUNDS)) ||
                       (p2_wins_q == 3'(WIN_ROUNDS)) ||
                       (round_num_q == 3'(MAX_ROUNDS));

   always_comb begin
      if (h1 > h2)      outcome = W_P1;
      else if (h2 > h1) outcome = W_P2;
      else              outcome = W_DRAW;
   end

   always_comb begin
      if (p1_wins_q > p2_wins_q)      match_lead = W_P1;
      else if (p2_wins_q > p1_wins_q) match_lead = W_P2;
      else                            match_lead = W_DRAW;
   end

   always_comb begin
      state_d        = state_q;
      p1_wins_d      = p1_wins_q;
      p2_wins_d      = p2_wins_q;
      round_num_d    = round_num_q;
      round_winner_d = round_winner_q;
      winner_d       = winner_q;
      time_load      = 1'b0;
      time_en        = 1'b0;
      hold_load      = 1'b0;
      hold_en        = 1'b0;

      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (bus.start) begin
               p1_wins_d      = '0;
               p2_wins_d      = '0;
               round_winner_d = W_NONE;
               winner_d       = W_NONE;
               round_num_d    = 3'd1;
               time_load      = 1'b1;
               state_d        = S_NEXT_ROUND;
            end
         end
         S_NEXT_ROUND: begin
            state_d = S_FIGHT;
         end
         S_FIGHT: begin
            // A tick that coincides with the deciding cycle is dropped.
            if (round_over) begin
               round_winner_d = outcome;
               if (outcome == W_P1) p1_wins_d = sat_inc3(p1_wins_q);
               if (outcome == W_P2) p2_wins_d = sat_inc3(p2_wins_q);
               hold_load      = 1'b1;
               state_d        = S_ROUND_END;
            end else begin
               time_en = 1'b1;
            end
         end
         S_ROUND_END: begin
            hold_en = 1'b1;
            if (hold_zero) begin
               if (match_done) begin
                  winner_d = match_lead;
                  state_d  = S_GAME_OVER;
               end else begin
                  round_num_d    = sat_inc3(round_num_q);
                  round_winner_d = W_NONE;
                  time_load      = 1'b1;
                  state_d        = S_NEXT_ROUND;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         p1_wins_q      <= '0;
         p2_wins_q      <= '0;
         round_num_q    <= '0;
         round_winner_q <= W_NONE;
         winner_q       <= W_NONE;
      end else begin
         state_q        <= state_d;
         p1_wins_q      <= p1_wins_d;
         p2_wins_q      <= p2_wins_d;
         round_num_q    <= round_num_d;
         round_winner_q <= round_winner_d;
         winner_q       <= winner_d;
      end
   end

   // Gated with reset so the players drop into reset the instant we do.
   assign bus.player_rst_n = reset &&
                             ((state_q == S_FIGHT) || (state_q == S_ROUND_END));
   assign bus.fighting     = (state_q == S_FIGHT);
   assign bus.game_over    = (state_q == S_GAME_OVER);
   assign bus.time_left    = time_cnt;
   assign bus.round_num    = round_num_q;
   assign bus.p1_wins      = p1_wins_q;
   assign bus.p2_wins      = p2_wins_q;
   assign bus.round_winner = round_winner_q;
   assign bus.winner       = winner_q;

endmodule

// File: doc/match_referee.md
# match_referee

Round and match controller that sits downstream of the two player state machines. It consumes their 4-bit state words (place and health) and decides round winners by KO or timeout. It keeps round wins and drives the players' reset so each round restarts from the initial state. It also exports timer, score and winner data for the display logic.

## Interface
Parameters:
- ROUND_TIME, 45: round length in `tick` periods (≤ 63).
- WIN_ROUNDS, 2: rounds needed to win the match.
- MAX_ROUNDS, 5: hard cap on rounds played.
- HOLD_TICKS, 3: `tick` periods the round result is held before the next round.

Ports (reset is asynchronous, active-low; clock is `clk`):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  level-sampled each cycle; starts a match from IDLE or GAME_OVER.
- tick  in  1  one-cycle enable, 1 Hz game time base.
- p1_state  in  4  player 1 word: [3:2] place, [1:0] health.
- p2_state  in  4  player 2 word, same encoding.
- player_rst_n  out  1  active-low reset to both player FSMs.
- fighting  out  1  high only in FIGHT; upstream gates actions with it.
- time_left  out  6  remaining round time.
- round_num  out  3  current round, 1-based; 0 when idle.
- p1_wins, p2_wins  out  3  round wins per player.
- round_winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- game_over  out  1  match finished.
- winner  out  2  match winner; same code as round_winner.

## Operation
- States:
  - IDLE
  - FIGHT
  - ROUND_END
  - NEXT_ROUND
  - GAME_OVER
- Reset (async): go to IDLE.
  - All outputs are 0, including player_rst_n = 0, so the players are held in reset.
- IDLE or GAME_OVER, with start = 1:
  - Clear the win counters, round_winner, game_over and winner.
  - Set round_num = 1 and time_left = ROUND_TIME.
  - Go to NEXT_ROUND.
- NEXT_ROUND: lasts one cycle with player_rst_n = 0, then go to FIGHT. player_rst_n = 1 in FIGHT and ROUND_END.
- FIGHT:
  - fighting = 1.
  - When tick = 1 and time_left > 0, decrement time_left.
  - The round ends when either health is 0 or time_left is 0.
- Round outcome (one rule covers both KO and timeout):
  - Higher health wins the round.
  - Equal health is a draw; this includes a double KO and a timeout at equal health.
  - The place field is ignored.
- On round end:
  - Register round_winner.
  - Increment the winner's counter. Draws increment neither counter.
  - Load the hold counter with HOLD_TICKS and go to ROUND_END.
- ROUND_END:
  - fighting = 0, and the player states stay frozen.
  - Decrement the hold counter on each tick.
  - When it reaches 0, check for match end:
    - If either counter equals WIN_ROUNDS or round_num equals MAX_ROUNDS, go to GAME_OVER.
    - Otherwise increment round_num, reload time_left, clear round_winner and go to NEXT_ROUND.
- GAME_OVER:
  - game_over = 1.
  - winner is the player with more wins; 11 if the counts are equal.
  - player_rst_n = 0.
  - Counters are held.
- Width rules:
  - Counters saturate and never wrap.
  - time_left never goes below 0.

## Timing
- Round-end detection is synchronous. It is evaluated from the p*_state values sampled at the clock edge.
  - On that same edge: the state moves to ROUND_END and round_winner and the win counter update.
  - fighting drops in the cycle after the KO condition appears.
- A tick on the KO cycle is ignored; time_left keeps its pre-KO value.
- When tick brings time_left from 1 to 0, the round ends at the next edge (one-cycle latency).
- The start-to-FIGHT sequence is IDLE → NEXT_ROUND → FIGHT, two edges in total.
- start held high in FIGHT or ROUND_END has no effect.
- Asynchronous reset mid-round:
  - Immediately returns to IDLE with all outputs at their reset values.
  - player_rst_n asserts combinationally with reset and is not delayed.

## Structure
- Shared package (also used by the player FSMs):
  - State-word field slices: PLACE [3:2], HEALTH [1:0].
  - HEALTH_FULL = 3.
  - Winner codes W_NONE, W_P1, W_P2, W_DRAW.
  - Referee state encoding.
- Sub-module `round_timer`: a loadable down counter.
  - Inputs: load, load_val, tick, en.
  - Outputs: count and zero.
  - Instantiated twice: once as the round clock, once as the hold counter.
- Outcome comparison and the FSM stay in `match_referee`.

## Test plan
- Reset, start pulse: player_rst_n is low for exactly one cycle, then fighting = 1, round_num = 1, time_left = 45.
- In FIGHT, p2_state = 4'b1000 (health 0) with p1_state = 4'b0111: round_winner = 01 and p1_wins = 1 on the next edge; after 3 ticks, round_num = 2 with a new player_rst_n pulse.
- 45 ticks with p1 health 2, p2 health 1: time_left reaches 0, P1 wins by timeout. Repeat with equal health: round_winner = 11 and the counters are unchanged.
- Both healths drop to 0 on the same cycle: draw. After five consecutive draws: game_over = 1, winner = 11.
- P2 wins two rounds: game_over = 1, winner = 10, p2_wins = 2, player_rst_n = 0; start then clears the counters and begins round 1.
- Assert reset during ROUND_END and during FIGHT with tick high: outputs go to 0 asynchronously and the block stays in IDLE until start.
